// File: rtl/uart_sdram_pkg.sv
// rtl/uart_sdram_pkg.sv - shared pacer state encoding and UART frame timing derivation
package uart_sdram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAPT = 2'd2,
    S_GAP  = 2'd3
  } pacer_state_t;

  function automatic int calc_baud_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // One start bit, eight data bits and one stop bit, plus idle guard cycles.
  function automatic int calc_gap_cyc(input int clk_freq, input int uart_bps, input int guard_cyc);
    return calc_baud_cnt(clk_freq, uart_bps) * 10 + guard_cyc;
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// rtl/byte_gap_timer.sv - counts GAP_CYC cycles after start, pulses expire on the last one
module byte_gap_timer #(
  parameter int GAP_CYC = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expire
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] LAST = GAP_W'(GAP_CYC - 1);

  logic [GAP_W-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == LAST) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + GAP_W'(1);
      end
    end
  end

  assign expire = run_q && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_pacer.sv
// rtl/uart_tx_pacer.sv - drains one burst from the SDRAM read FIFO into uart_tx, one byte per frame
module uart_tx_pacer
  import uart_sdram_pkg::*;
#(
  parameter int UART_BPS  = 9600,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int GUARD_CYC = 16,
  parameter int CNT_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] burst_num,
  input  logic [9:0]       rd_fifo_num,
  input  logic [7:0]       rd_fifo_rd_data,
  output logic             rd_en,
  output logic             tx_flag,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done
);

  localparam int GAP_CYC = calc_gap_cyc(CLK_FREQ, UART_BPS, GUARD_CYC);

  pacer_state_t     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             rd_en_q, rd_en_d;
  logic             tx_flag_q, tx_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       tx_data_q;
  logic             gap_start, gap_expire;
  logic             fifo_ne, start_ok;

  assign fifo_ne  = (rd_fifo_num != 10'd0);
  assign start_ok = (burst_num != '0) && (CNT_W'(rd_fifo_num) >= burst_num);

  byte_gap_timer #(
    .GAP_CYC (GAP_CYC)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .start  (gap_start),
    .expire (gap_expire)
  );

  // The pop decision is made one cycle ahead so the registered rd_en is high
  // during REQ itself; REQ only stalls while that lookahead saw an empty FIFO.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rd_en_d     = 1'b0;
    tx_flag_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    gap_start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d     = S_REQ;
          busy_d      = 1'b1;
          rd_en_d     = 1'b1;
          remaining_d = burst_num - CNT_W'(1);
        end
      end
      S_REQ: begin
        if (rd_en_q) begin
          state_d   = S_CAPT;
          tx_flag_d = 1'b1;
        end else if (fifo_ne) begin
          rd_en_d     = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
      S_CAPT: begin
        gap_start = 1'b1;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_expire) begin
          if (remaining_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_REQ;
            if (fifo_ne) begin
              rd_en_d     = 1'b1;
              remaining_d = remaining_q - CNT_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      rd_en_q     <= 1'b0;
      tx_flag_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_en_q     <= rd_en_d;
      tx_flag_q   <= tx_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      if (state_q == S_CAPT) begin
        tx_data_q <= rd_fifo_rd_data;
      end
    end
  end

  // FIFO q is valid during CAPT, alongside tx_flag; the copy holds it afterwards.
  assign tx_data = (state_q == S_CAPT) ? rd_fifo_rd_data : tx_data_q;
  assign rd_en   = rd_en_q;
  assign tx_flag = tx_flag_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
